// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default RAM address and data widths
//   HSTALL_W                : width of the saturating hazard-stall counter
//   req_idx_t               : index of one of the two requesters
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned HSTALL_W   = 16;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, asynchronous active-low reset
//   req      : request vector, bit i from requester i
//   enable   : when low no grant is issued and the pointer holds
//   gnt      : one-hot (or zero) combinational grant; forced to 0 during reset
//   ptr      : current priority pointer, the winner when both request
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt,
  output req_idx_t   ptr
);

  req_idx_t ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (rst && enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr_q == 1'b1) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // After a grant the loser gets priority; with no grant the pointer holds.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM (registered read port, write port with a one-cycle write-delay stage)
// between two requesters. Read and write ports are arbitrated independently, each by
// its own round-robin arbiter. A read to the address written in the previous cycle is
// stalled, since the RAM commits that write on the same edge the read samples.
//   clk, rst                       : clock, asynchronous active-low reset
//   rd_req_*, rd_addr_*            : read requests and addresses
//   rd_gnt_*                       : combinational read grants
//   rd_valid_*, rd_data            : read response, one cycle after the grant
//   wr_req_*, wr_addr_*, wr_data_* : write requests, addresses and data
//   wr_gnt_*                       : combinational write grants
//   raddr_0, ren_0, rdata_0        : RAM read port
//   waddr_0, wdata_0, wen_0        : RAM write port (before the RAM's delay stage)
//   hazard_stalls                  : saturating count of hazard-stalled read cycles
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req_0,
  input  logic                rd_req_1,
  input  logic [ADDR_W-1:0]   rd_addr_0,
  input  logic [ADDR_W-1:0]   rd_addr_1,
  output logic                rd_gnt_0,
  output logic                rd_gnt_1,
  output logic                rd_valid_0,
  output logic                rd_valid_1,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                wr_req_0,
  input  logic                wr_req_1,
  input  logic [ADDR_W-1:0]   wr_addr_0,
  input  logic [ADDR_W-1:0]   wr_addr_1,
  input  logic [DATA_W-1:0]   wr_data_0,
  input  logic [DATA_W-1:0]   wr_data_1,
  output logic                wr_gnt_0,
  output logic                wr_gnt_1,
  output logic [ADDR_W-1:0]   raddr_0,
  output logic                ren_0,
  input  logic [DATA_W-1:0]   rdata_0,
  output logic [ADDR_W-1:0]   waddr_0,
  output logic [DATA_W-1:0]   wdata_0,
  output logic                wen_0,
  output logic [HSTALL_W-1:0] hazard_stalls
);

  logic [1:0]          rd_gnt, wr_gnt;
  req_idx_t            rd_ptr;
  req_idx_t            wr_ptr_unused;
  req_idx_t            rd_cand;
  logic [ADDR_W-1:0]   rd_cand_addr;
  logic                hazard;

  logic                wp_valid_q;
  logic [ADDR_W-1:0]   wp_addr_q;
  logic                rd_valid_0_q, rd_valid_1_q;
  logic [HSTALL_W-1:0] stalls_q, stalls_d;

  // Would-be read winner, evaluated as if the arbiter were enabled.
  always_comb begin
    if (rd_req_0 && rd_req_1) begin
      rd_cand = rd_ptr;
    end else begin
      rd_cand = rd_req_1;
    end
    rd_cand_addr = (rd_cand == 1'b1) ? rd_addr_1 : rd_addr_0;
  end

  // Only the would-be winner is checked; the other requester is not tried instead.
  assign hazard = (rd_req_0 || rd_req_1) && wp_valid_q && (rd_cand_addr == wp_addr_q);

  rr_arb2 u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({rd_req_1, rd_req_0}),
    .enable (!hazard),
    .gnt    (rd_gnt),
    .ptr    (rd_ptr)
  );

  rr_arb2 u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({wr_req_1, wr_req_0}),
    .enable (1'b1),
    .gnt    (wr_gnt),
    .ptr    (wr_ptr_unused)
  );

  assign rd_gnt_0 = rd_gnt[0];
  assign rd_gnt_1 = rd_gnt[1];
  assign wr_gnt_0 = wr_gnt[0];
  assign wr_gnt_1 = wr_gnt[1];

  // RAM port muxes; idle ports are driven to zero.
  always_comb begin
    raddr_0 = '0;
    waddr_0 = '0;
    wdata_0 = '0;
    if (rd_gnt[1]) begin
      raddr_0 = rd_addr_1;
    end else if (rd_gnt[0]) begin
      raddr_0 = rd_addr_0;
    end
    if (wr_gnt[1]) begin
      waddr_0 = wr_addr_1;
      wdata_0 = wr_data_1;
    end else if (wr_gnt[0]) begin
      waddr_0 = wr_addr_0;
      wdata_0 = wr_data_0;
    end
  end

  assign ren_0 = |rd_gnt;
  assign wen_0 = |wr_gnt;

  always_comb begin
    stalls_d = stalls_q;
    if (hazard && (stalls_q != {HSTALL_W{1'b1}})) begin
      stalls_d = stalls_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_valid_q   <= 1'b0;
      wp_addr_q    <= '0;
      rd_valid_0_q <= 1'b0;
      rd_valid_1_q <= 1'b0;
      stalls_q     <= '0;
    end else begin
      wp_valid_q   <= wen_0;
      wp_addr_q    <= waddr_0;
      rd_valid_0_q <= rd_gnt[0];
      rd_valid_1_q <= rd_gnt[1];
      stalls_q     <= stalls_d;
    end
  end

  assign rd_valid_0    = rd_valid_0_q;
  assign rd_valid_1    = rd_valid_1_q;
  assign rd_data       = rdata_0;
  assign hazard_stalls = stalls_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAM (registered read,
// one-cycle write-delay stage). Expected read responses are queued at grant time and
// popped by an independent monitor whenever a read response appears.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_0, rd_req_1;
  logic [4:0]  rd_addr_0, rd_addr_1;
  logic        rd_gnt_0, rd_gnt_1;
  logic        rd_valid_0, rd_valid_1;
  logic [31:0] rd_data;
  logic        wr_req_0, wr_req_1;
  logic [4:0]  wr_addr_0, wr_addr_1;
  logic [31:0] wr_data_0, wr_data_1;
  logic        wr_gnt_0, wr_gnt_1;
  logic [4:0]  raddr_0;
  logic        ren_0;
  logic [31:0] rdata_0;
  logic [4:0]  waddr_0;
  logic [31:0] wdata_0;
  logic        wen_0;
  logic [15:0] hazard_stalls;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .rd_req_0      (rd_req_0),
    .rd_req_1      (rd_req_1),
    .rd_addr_0     (rd_addr_0),
    .rd_addr_1     (rd_addr_1),
    .rd_gnt_0      (rd_gnt_0),
    .rd_gnt_1      (rd_gnt_1),
    .rd_valid_0    (rd_valid_0),
    .rd_valid_1    (rd_valid_1),
    .rd_data       (rd_data),
    .wr_req_0      (wr_req_0),
    .wr_req_1      (wr_req_1),
    .wr_addr_0     (wr_addr_0),
    .wr_addr_1     (wr_addr_1),
    .wr_data_0     (wr_data_0),
    .wr_data_1     (wr_data_1),
    .wr_gnt_0      (wr_gnt_0),
    .wr_gnt_1      (wr_gnt_1),
    .raddr_0       (raddr_0),
    .ren_0         (ren_0),
    .rdata_0       (rdata_0),
    .waddr_0       (waddr_0),
    .wdata_0       (wdata_0),
    .wen_0         (wen_0),
    .hazard_stalls (hazard_stalls)
  );

  // Behavioural RAM; the delay stage is deliberately not reset.
  logic [31:0] mem [0:31];
  logic        wen_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;

  always @(posedge clk) begin
    if (ren_0) rdata_0 <= mem[raddr_0];
    wen_d   <= wen_0;
    waddr_d <= waddr_0;
    wdata_d <= wdata_0;
    if (wen_d) mem[waddr_d] <= wdata_d;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    wr_req_0  = 1'b1;
    wr_addr_0 = a;
    wr_data_0 = d;
    mid();
    chk("preload_wr_gnt", {31'd0, wr_gnt_0}, 32'd1);
    step();
    wr_req_0 = 1'b0;
  endtask

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      mid();
      if (rd_valid_0 || rd_valid_1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got valid0=%0b valid1=%0b expected no response (t=%0t)",
                   rd_valid_0, rd_valid_1, $time);
        end else begin
          e = sb.pop_front();
          chk("rd_route", {30'd0, rd_valid_1, rd_valid_0}, {30'd0, e.id, ~e.id});
          chk("rd_data", rd_data, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    rd_req_0 = 1'b0; rd_req_1 = 1'b0; rd_addr_0 = '0; rd_addr_1 = '0;
    wr_req_0 = 1'b0; wr_req_1 = 1'b0; wr_addr_0 = '0; wr_addr_1 = '0;
    wr_data_0 = '0; wr_data_1 = '0;

    // Reset: requests held high must not be granted.
    rd_req_0 = 1'b1;
    wr_req_0 = 1'b1;
    mid();
    chk("rst_rd_gnt", {30'd0, rd_gnt_1, rd_gnt_0}, 32'd0);
    chk("rst_wr_gnt", {30'd0, wr_gnt_1, wr_gnt_0}, 32'd0);
    chk("rst_wen", {31'd0, wen_0}, 32'd0);
    step();
    step();
    rd_req_0 = 1'b0;
    wr_req_0 = 1'b0;
    rst = 1'b1;
    mid();
    chk("post_rst_valid", {30'd0, rd_valid_1, rd_valid_0}, 32'd0);
    chk("post_rst_stalls", {16'd0, hazard_stalls}, 32'd0);
    step();

    // Preload memory through the write port.
    wr0(5'd1, 32'd5);
    wr0(5'd2, 32'd9);
    wr0(5'd4, 32'd7);
    wr0(5'd6, 32'h66);
    step();
    step();

    // Write then read the same address: one stall.
    wr_req_0 = 1'b1; wr_addr_0 = 5'd3; wr_data_0 = 32'd12;
    mid();
    chk("w_gnt0", {31'd0, wr_gnt_0}, 32'd1);
    chk("w_wen", {31'd0, wen_0}, 32'd1);
    chk("w_waddr", {27'd0, waddr_0}, 32'd3);
    chk("w_wdata", wdata_0, 32'd12);
    step();
    wr_req_0 = 1'b0;
    rd_req_1 = 1'b1; rd_addr_1 = 5'd3;
    mid();
    chk("haz_no_gnt", {31'd0, rd_gnt_1}, 32'd0);
    chk("haz_no_ren", {31'd0, ren_0}, 32'd0);
    step();
    mid();
    chk("haz_stalls1", {16'd0, hazard_stalls}, 32'd1);
    chk("haz_gnt_t2", {31'd0, rd_gnt_1}, 32'd1);
    chk("haz_raddr", {27'd0, raddr_0}, 32'd3);
    push(1'b1, 32'd12);
    step();
    rd_req_1 = 1'b0;
    step();

    // Contention: pointer starts at 0.
    rd_req_0 = 1'b1; rd_addr_0 = 5'd1;
    rd_req_1 = 1'b1; rd_addr_1 = 5'd2;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("cont_gnt", {30'd0, rd_gnt_1, rd_gnt_0}, (i % 2 == 0) ? 32'd1 : 32'd2);
      push((i % 2) == 1, (i % 2 == 0) ? 32'd5 : 32'd9);
      step();
    end
    rd_req_0 = 1'b0;
    rd_req_1 = 1'b0;

    // Same-cycle read and write to one address: read sees the old value.
    rd_req_0 = 1'b1; rd_addr_0 = 5'd4;
    wr_req_1 = 1'b1; wr_addr_1 = 5'd4; wr_data_1 = 32'd8;
    mid();
    chk("raw_rd_gnt", {30'd0, rd_gnt_1, rd_gnt_0}, 32'd1);
    chk("raw_wr_gnt", {30'd0, wr_gnt_1, wr_gnt_0}, 32'd2);
    push(1'b0, 32'd7);
    step();
    rd_req_0 = 1'b0;
    wr_req_1 = 1'b0;
    step();
    rd_req_0 = 1'b1; rd_addr_0 = 5'd4;
    mid();
    chk("raw_late_gnt", {31'd0, rd_gnt_0}, 32'd1);
    chk("raw_stalls", {16'd0, hazard_stalls}, 32'd1);
    push(1'b0, 32'd8);
    step();
    rd_req_0 = 1'b0;

    // No false stall on a different address.
    wr_req_0 = 1'b1; wr_addr_0 = 5'd5; wr_data_0 = 32'd33;
    step();
    wr_req_0 = 1'b0;
    rd_req_1 = 1'b1; rd_addr_1 = 5'd6;
    mid();
    chk("nfs_gnt", {31'd0, rd_gnt_1}, 32'd1);
    chk("nfs_stalls", {16'd0, hazard_stalls}, 32'd1);
    push(1'b1, 32'h66);
    step();
    rd_req_1 = 1'b0;
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Saturation: reset the counter, then stall continuously.
    rst = 1'b0;
    step();
    rst = 1'b1;
    mid();
    chk("sat_start", {16'd0, hazard_stalls}, 32'd0);
    step();
    wr_req_0 = 1'b1; wr_addr_0 = 5'd10; wr_data_0 = 32'd1;
    step();
    rd_req_1 = 1'b1; rd_addr_1 = 5'd10;
    repeat (100) step();
    mid();
    chk("sat_100", {16'd0, hazard_stalls}, 32'd100);
    repeat (65440) step();
    mid();
    chk("sat_ffff", {16'd0, hazard_stalls}, 32'h0000_ffff);
    chk("sat_no_gnt", {31'd0, rd_gnt_1}, 32'd0);
    step();
    wr_req_0 = 1'b0;
    mid();
    chk("sat_last_stall", {31'd0, rd_gnt_1}, 32'd0);
    step();
    mid();
    chk("sat_release_gnt", {31'd0, rd_gnt_1}, 32'd1);
    chk("sat_hold", {16'd0, hazard_stalls}, 32'h0000_ffff);

    // Reset while that read response is in flight: it must be dropped.
    step();
    rst = 1'b0;
    rd_req_1 = 1'b0;
    mid();
    chk("rst_drop_valid", {30'd0, rd_valid_1, rd_valid_0}, 32'd0);
    chk("rst_clr_stalls", {16'd0, hazard_stalls}, 32'd0);
    step();
    rst = 1'b1;
    step();
    step();
    chk("sb_final", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter sharing one `RAM_1_3_32_32`-style memory (one registered read port, one write port with a one-cycle write-delay stage) between two datapath clients. For example, the `dynamic_arch` core and a loader/checker. Each RAM port gets an independent round-robin arbiter. The block stalls a read issued in the cycle immediately after a write to the same address, which would otherwise return stale data. Read responses are routed back to the requester that was granted.

## Interface
- `ADDR_W`, 5: RAM address width.
- `DATA_W`, 32: RAM data width.
- `clk`  in  1: clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `rd_req_0` / `rd_req_1`  in  1: read request; held until granted.
- `rd_addr_0` / `rd_addr_1`  in  ADDR_W: read address; stable while `rd_req_i` is high.
- `rd_gnt_0` / `rd_gnt_1`  out  1: combinational read grant.
- `rd_valid_0` / `rd_valid_1`  out  1: read data valid for that requester.
- `rd_data`  out  DATA_W: shared read data, equal to `rdata_0`.
- `wr_req_0` / `wr_req_1`  in  1: write request; held until granted.
- `wr_addr_0` / `wr_addr_1`  in  ADDR_W: write address.
- `wr_data_0` / `wr_data_1`  in  DATA_W: write data.
- `wr_gnt_0` / `wr_gnt_1`  out  1: combinational write grant.
- `raddr_0`  out  ADDR_W: RAM read address.
- `ren_0`  out  1: RAM read enable.
- `rdata_0`  in  DATA_W: RAM registered read data.
- `waddr_0`  out  ADDR_W: RAM write address.
- `wdata_0`  out  DATA_W: RAM write data.
- `wen_0`  out  1: RAM write enable, pre-delay.
- `hazard_stalls`  out  16: saturating count of hazard-stalled read cycles.

## Operation
- Read and write ports are arbitrated independently. A read and a write may both be granted in the same cycle, to the same or to different requesters.
- Each port uses 2-way round-robin:
  - Priority pointer `p` is 0 after reset.
  - If only one requester asks, that requester wins.
  - If both ask, requester `p` wins.
  - After any grant, `p` becomes the index that was not granted.
  - The pointer is unchanged when there is no grant, including a hazard-stalled cycle.
- When granted, a requester's address and data drive the RAM port that cycle, with `ren_0`/`wen_0` = 1.
  - When no grant is given, `wen_0` = 0 and `ren_0` = 0.
  - Addresses and data are don't-care when no grant is given, but are driven to 0.
- Write tracking: `wp_valid`/`wp_addr` register whether a write was granted last cycle and its address.
- Hazard: a read candidate is stalled when `wp_valid` = 1 and the candidate's address equals `wp_addr`.
  - The RAM commits that write at the same edge as the read sample, so the read would return old data.
  - On a stall: no read grant, the arbiter re-evaluates next cycle, and `hazard_stalls` increments, saturating at 0xFFFF.
  - Only the would-be winner is checked. There is no bypass to the other requester in that cycle.
- Read and write granted in the same cycle to the same address: the read returns the pre-write value (read-before-write). This is legal, not a hazard.
- Response routing: `rd_valid_i` is a register equal to `rd_gnt_i` of the previous cycle. `rd_data` = `rdata_0` passthrough.

## Timing
- Grant in cycle t → `rd_valid_i` = 1 in cycle t+1, with data on `rd_data`. Read latency is 1.
- Write granted in t → RAM updated at the end of t+1. A read of that address is first grantable in t+2 and returns new data in t+3.
- Back-to-back grants are allowed every cycle on both ports.
- Reset values: `rd_valid_*` = 0, `hazard_stalls` = 0, both pointers = 0, `wp_valid` = 0. Grants are forced to 0 while `rst` = 0.
- Reset mid-operation:
  - An in-flight read response is dropped (`rd_valid` is cleared).
  - A write granted in the cycle before reset still lands, because the RAM delay stage is not reset. This is documented and is not cancelled.

## Structure
- Shared package `ram_arb_pkg`: `ADDR_W`/`DATA_W` defaults, `HSTALL_W` = 16, `req_idx_t` (1-bit requester index).
- One sub-module `rr_arb2` (req[1:0], enable → gnt[1:0], pointer register), instantiated twice:
  - read port: enable = not hazard;
  - write port: enable = 1.
- Top level holds the write tracker, the hazard comparator, the response registers and the stall counter.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles, then release → all grants/valids 0, `hazard_stalls` = 0.
- Write then read:
  - Stimulus: req 0 writes 12 to addr 3 (t0); req 1 reads addr 3 from t1.
  - Expected: read stalled in t1 (`hazard_stalls` = 1), granted t2, `rd_valid_1` at t3 with `rd_data` = 12.
- Contention:
  - Stimulus: both requesters hold read requests to addrs 1 and 2 (values 5 and 9) for 4 cycles.
  - Expected: grants alternate 0,1,0,1; `rd_data` = 5,9,5,9 with matching `rd_valid`.
- Same-cycle RAW:
  - Stimulus: addr 4 holds 7; read addr 4 (req 0) and write 8 to addr 4 (req 1) in the same cycle.
  - Expected: read returns 7; a later read returns 8.
- No false stall: write to addr 5 at t0, read addr 6 at t1 → read granted at t1, `hazard_stalls` unchanged.
- Saturation and reset:
  - Force 65540 hazard stalls → `hazard_stalls` = 0xFFFF.
  - Assert `rst` while a read is outstanding → `rd_valid` = 0 next cycle and counter = 0.
